// File: rtl/midi_pkg.sv
// MIDI receiver shared definitions: status constants, FSM state types and
// the UART bit-divisor helper.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF        = 4'h8;
   localparam logic [3:0] NOTE_ON         = 4'h9;
   localparam logic [7:0] SYS_COMMON_BASE = 8'hF0;
   localparam logic [7:0] REALTIME_BASE   = 8'hF8;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      WAIT_STATUS,
      WAIT_DATA1,
      WAIT_DATA2
   } parse_state_t;

   // Clocks per serial bit, truncated.
   function automatic int unsigned bit_divisor(input int unsigned clock_rate_hz,
                                               input int unsigned baud_rate);
      return clock_rate_hz / baud_rate;
   endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI UART receiver: 2-flop synchroniser, start-edge detect, bit-centre
// sampling with a down-counting bit timer, byte-valid / frame-error pulses.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for synchronised 1->0 edge
// RX_START | timing to the start-bit centre, rejecting false starts
// RX_DATA  | sampling 8 data bits LSB first at bit centres
// RX_STOP  | sampling the stop bit, then pulse valid or frame error
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int unsigned DIV = 1600
) (
   input  logic       clk_sys,
   input  logic       rst_b,
   input  logic       rx_async,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_error
);

   localparam int CNT_W = $clog2(DIV + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic sync1_q, sync2_q, prev_q;
   rx_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic byte_valid_q, byte_valid_d;
   logic frame_error_q, frame_error_d;
   logic cnt_tc;

   assign cnt_tc = (cnt_q == CNT_ONE);

   // Synchroniser, edge-history flop and RX state registers.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         prev_q        <= 1'b1;
         state_q       <= RX_IDLE;
         cnt_q         <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         byte_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         sync1_q       <= rx_async;
         sync2_q       <= sync1_q;
         prev_q        <= sync2_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         byte_valid_q  <= byte_valid_d;
         frame_error_q <= frame_error_d;
      end
   end

   // Next-state: bit timer reloads at each sample; pulses default low.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      byte_valid_d  = 1'b0;
      frame_error_d = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (prev_q && !sync2_q) begin
               state_d = RX_START;
               cnt_d   = CNT_HALF;
            end
         end
         RX_START: begin
            if (cnt_tc) begin
               if (sync2_q) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d   = RX_DATA;
                  cnt_d     = CNT_FULL;
                  bit_cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         RX_DATA: begin
            if (cnt_tc) begin
               shift_d = {sync2_q, shift_q[7:1]};
               cnt_d   = CNT_FULL;
               if (bit_cnt_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         RX_STOP: begin
            if (cnt_tc) begin
               state_d = RX_IDLE;
               if (sync2_q) begin
                  byte_valid_d = 1'b1;
               end else begin
                  frame_error_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // shift_q only moves in RX_DATA, so it is stable while byte_valid is high.
   assign byte_data   = shift_q;
   assign byte_valid  = byte_valid_q;
   assign frame_error = frame_error_q;

endmodule

// File: rtl/midi_note_receiver.sv
// MIDI note receiver top: UART front end plus Note On/Off parser with
// running status, driving a monophonic note index, gate and velocity.
// Build option OMNI_MODE_EN: accept Note On/Off on all 16 channels instead
// of only CHANNEL.
//
// state       | meaning
// WAIT_STATUS | no usable running status, data bytes discarded
// WAIT_DATA1  | note status held, expecting the note number
// WAIT_DATA2  | note number held, expecting the velocity
module midi_note_receiver
   import midi_pkg::*;
#(
   parameter int unsigned CLOCK_RATE_HZ = 50000000,
   parameter int unsigned BAUD_RATE     = 31250,
   parameter int unsigned CHANNEL       = 0
) (
   input  logic       inCLK,
   input  logic       inRST_N,
   input  logic       inMidiRx,
   output logic [6:0] outMidiFrequencyIndex,
   output logic       outGate,
   output logic [6:0] outVelocity,
   output logic       outNoteEvent,
   output logic       outFrameError
);

   localparam int unsigned DIV = bit_divisor(CLOCK_RATE_HZ, BAUD_RATE);

   logic [7:0] rx_byte;
   logic rx_valid;

   midi_uart_rx #(.DIV(DIV)) u_uart_rx (
      .clk_sys     (inCLK),
      .rst_b       (inRST_N),
      .rx_async    (inMidiRx),
      .byte_data   (rx_byte),
      .byte_valid  (rx_valid),
      .frame_error (outFrameError)
   );

   parse_state_t pstate_q, pstate_d;
   logic is_on_q, is_on_d;
   logic [6:0] note_q, note_d;
   logic [6:0] index_q, index_d;
   logic [6:0] vel_q, vel_d;
   logic gate_q, gate_d;
   logic event_q, event_d;
   logic chan_ok;
   logic [3:0] status_hi;

   assign status_hi = rx_byte[7:4];

`ifdef OMNI_MODE_EN
   assign chan_ok = 1'b1;
`else
   assign chan_ok = (rx_byte[3:0] == CHANNEL[3:0]);
`endif

   // Parser state and note outputs.
   always_ff @(posedge inCLK or negedge inRST_N) begin
      if (!inRST_N) begin
         pstate_q <= WAIT_STATUS;
         is_on_q  <= 1'b0;
         note_q   <= '0;
         index_q  <= '0;
         vel_q    <= '0;
         gate_q   <= 1'b0;
         event_q  <= 1'b0;
      end else begin
         pstate_q <= pstate_d;
         is_on_q  <= is_on_d;
         note_q   <= note_d;
         index_q  <= index_d;
         vel_q    <= vel_d;
         gate_q   <= gate_d;
         event_q  <= event_d;
      end
   end

   // Byte classification, running status and note apply.
   always_comb begin
      pstate_d = pstate_q;
      is_on_d  = is_on_q;
      note_d   = note_q;
      index_d  = index_q;
      vel_d    = vel_q;
      gate_d   = gate_q;
      event_d  = 1'b0;
      if (rx_valid) begin
         if (rx_byte[7]) begin
            // Realtime bytes may interleave anywhere and leave the parser untouched.
            if (rx_byte < REALTIME_BASE) begin
               if (rx_byte >= SYS_COMMON_BASE) begin
                  pstate_d = WAIT_STATUS;
               end else if (chan_ok && (status_hi == NOTE_OFF || status_hi == NOTE_ON)) begin
                  pstate_d = WAIT_DATA1;
                  is_on_d  = (status_hi == NOTE_ON);
               end else begin
                  pstate_d = WAIT_STATUS;
               end
            end
         end else begin
            case (pstate_q)
               WAIT_DATA1: begin
                  note_d   = rx_byte[6:0];
                  pstate_d = WAIT_DATA2;
               end
               WAIT_DATA2: begin
                  pstate_d = WAIT_DATA1;
                  if (is_on_q && rx_byte[6:0] != 7'd0) begin
                     index_d = note_q;
                     vel_d   = rx_byte[6:0];
                     gate_d  = 1'b1;
                     event_d = 1'b1;
                  end else if (gate_q && note_q == index_q) begin
                     // Release only the sounding note; index and velocity persist.
                     gate_d  = 1'b0;
                     event_d = 1'b1;
                  end
               end
               default: pstate_d = pstate_q;
            endcase
         end
      end
   end

   assign outMidiFrequencyIndex = index_q;
   assign outGate               = gate_q;
   assign outVelocity           = vel_q;
   assign outNoteEvent          = event_q;

endmodule

// File: tb/tb_midi_note_receiver.sv
// Bench for midi_note_receiver: directed scenarios then random byte streams,
// compared against a message-level model of note on/off handling.
module tb_midi_note_receiver;

   localparam int DIV = 16;
   localparam int FRAME = 10 * DIV;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic [6:0] idx_o;
   logic gate_o;
   logic [6:0] vel_o;
   logic ev_o;
   logic fe_o;

   midi_note_receiver #(
      .CLOCK_RATE_HZ(50000000),
      .BAUD_RATE    (3125000),
      .CHANNEL      (0)
   ) dut (
      .inCLK                (clk),
      .inRST_N              (rst_n),
      .inMidiRx             (rx),
      .outMidiFrequencyIndex(idx_o),
      .outGate              (gate_o),
      .outVelocity          (vel_o),
      .outNoteEvent         (ev_o),
      .outFrameError        (fe_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int ev_cnt = 0;
   int fe_cnt = 0;
   int last_ev_cyc = 0;
   int checks = 0;
   int errors = 0;
   int frame_start = 0;

   // Cycle counter and pulse tally, sampled on the falling edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (ev_o === 1'b1) begin
         ev_cnt = ev_cnt + 1;
         last_ev_cyc = cyc;
      end
      if (fe_o === 1'b1) fe_cnt = fe_cnt + 1;
   end

   // Reference model: running status byte (-1 = none), pending note (-1 = none).
   int m_run = -1;
   int m_note = -1;
   int m_idx = 0;
   int m_gate = 0;
   int m_vel = 0;
   int m_ev = 0;
   int m_fe = 0;

   task automatic model_reset();
      m_run = -1; m_note = -1; m_idx = 0; m_gate = 0; m_vel = 0;
   endtask

   task automatic model_byte(input int b);
      int hi, ch;
      bit ok;
      if (b >= 'hF8) return;
      if (b >= 'hF0) begin
         m_run = -1;
         return;
      end
      if (b >= 'h80) begin
         hi = b / 16;
         ch = b % 16;
`ifdef OMNI_MODE_EN
         ok = 1'b1;
`else
         ok = (ch == 0);
`endif
         if (ok && (hi == 8 || hi == 9)) begin
            m_run = b;
            m_note = -1;
         end else begin
            m_run = -1;
         end
         return;
      end
      if (m_run < 0) return;
      if (m_note < 0) begin
         m_note = b;
         return;
      end
      if (m_run / 16 == 9 && b > 0) begin
         m_idx = m_note; m_vel = b; m_gate = 1; m_ev++;
      end else if (m_gate == 1 && m_idx == m_note) begin
         m_gate = 0; m_ev++;
      end
      m_note = -1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".index"}, int'(idx_o), m_idx);
      check({tag, ".gate"}, int'(gate_o), m_gate);
      check({tag, ".velocity"}, int'(vel_o), m_vel);
      check({tag, ".events"}, ev_cnt, m_ev);
      check({tag, ".frame_errors"}, fe_cnt, m_fe);
   endtask

   // Drives the first ncyc cycles of a 10-bit frame (start, 8 data LSB first, stop).
   task automatic send_frame(input logic [7:0] b, input logic stop, input int ncyc);
      int k;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         if (c == 0) frame_start = cyc;
         k = c / DIV;
         if (k == 0) rx = 1'b0;
         else if (k <= 8) rx = b[k-1];
         else rx = stop;
      end
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         rx = 1'b1;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input int b);
      send_frame(8'(b), 1'b1, FRAME);
      idle(6);
      model_byte(b);
   endtask

   task automatic send_bad(input int b);
      send_frame(8'(b), 1'b0, FRAME);
      idle(6);
      m_fe++;
   endtask

   initial begin
      int r, d, nb;
      bit lat_ok;
      repeat (3) @(posedge clk);
      settle();
      check("reset.index", int'(idx_o), 0);
      check("reset.gate", int'(gate_o), 0);
      check("reset.velocity", int'(vel_o), 0);
      check("reset.event", int'(ev_o), 0);
      check("reset.frame_error", int'(fe_o), 0);
      @(posedge clk);
      rst_n = 1'b1;
      idle(4);

      // Note On with latency check on the final byte.
      send('h90); send('h45); send('h64);
      settle();
      check_all("s1");
      d = last_ev_cyc - frame_start;
      lat_ok = (d >= 155 && d <= 159);
      check("s1.latency_window", int'(lat_ok), 1);

      // Running status.
      send('h90); send('h3C); send('h40);
      settle();
      check_all("s2a");
      send('h40); send('h50);
      settle();
      check_all("s2b");

      // Off for a non-sounding note, then Note On velocity 0 release.
      send('h80); send('h3C); send('h00);
      settle();
      check_all("s3a");
      send('h90); send('h40); send('h00);
      settle();
      check_all("s3b");

      // Realtime byte between data bytes.
      send('h90); send('h45); send('hF8); send('h64);
      settle();
      check_all("s4");

      // Frame error keeps running status.
      send('h90); send('h3C); send('h40);
      send_bad('h45);
      settle();
      check_all("s5a");
      send('h45); send('h64);
      settle();
      check_all("s5b");

      // Foreign channel.
      send('h80); send('h45); send('h00);
      send('h91); send('h45); send('h64);
      settle();
      check_all("s6");

      // Reset mid-byte.
      send_frame(8'h90, 1'b1, 70);
      @(posedge clk);
      rst_n = 1'b0;
      rx = 1'b1;
      model_reset();
      settle();
      check("rst_mid.index", int'(idx_o), 0);
      check("rst_mid.gate", int'(gate_o), 0);
      check("rst_mid.velocity", int'(vel_o), 0);
      repeat (3) @(posedge clk);
      rst_n = 1'b1;
      idle(6);
      send('h45); send('h64);
      settle();
      check_all("rst_mid.after");
      send('h90); send('h45); send('h64);
      settle();
      check_all("rst_mid.recover");

      // Random byte stream.
      nb = 40;
      for (int i = 0; i < nb; i++) begin
         r = $urandom_range(0, 11);
         case (r)
            0: send('h90);
            1: send('h80);
            2: send('h91);
            3: send('hF8);
            4: send('hF0);
            5: send('hB0);
            6: send_bad($urandom_range(0, 255));
            7: send(0);
            8: send($urandom_range(1, 127));
            default: send(60 + 2 * $urandom_range(0, 2));
         endcase
         settle();
         check_all("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
